piece_queue: RTL and testbench

Parametrised next-piece generator with a configurable-depth preview queue and an integrated hold slot, replacing the single-entry next/hold logic inside `game_control`. It draws tetromino indices from a 16-bit LFSR, optionally through a 7-bag randomizer, and keeps `DEPTH` upcoming pieces visible for the side panel. It serves spawn and hold requests from the game FSM with a registered one-cycle spawn pulse.

---
 rtl/piece_queue.sv | 189 ++++++++++++++++++
 tb/tb_piece_queue.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piece_queue.sv
// rtl/piece_queue.sv - next-piece generator with preview queue and hold slot
//
// Draws tetromino indices from a 16-bit Galois LFSR and keeps DEPTH upcoming
// pieces in a preview queue. It also owns the hold slot and serves spawn/hold
// requests from the game FSM. Optional 7-bag draw: define PIECE_QUEUE_BAG_EN.
//
// Parameters:
//   DEPTH       number of visible upcoming pieces (1..6)
//   SEED        LFSR reset value (0 is replaced by 16'h0001)
// Ports:
//   clk         system clock
//   rst         synchronous active-high reset
//   spawn_req   pulse: previous piece locked, next piece needed
//   hold_req    pulse: player requests hold
//   hold_cur    index of the falling piece, sampled with hold_req
//   spawn_valid pulse: a new current piece is presented
//   spawn_idx   index of the new current piece
//   preview     queued pieces, preview[2:0] is next; empty slots read 7
//   hold_idx    held piece, 7 when empty
//   hold_used   a hold has already been taken for the current piece
//   ready       all DEPTH queue slots are filled
module piece_queue #(
  parameter int          DEPTH = 3,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               spawn_req,
  input  logic               hold_req,
  input  logic [2:0]         hold_cur,
  output logic               spawn_valid,
  output logic [2:0]         spawn_idx,
  output logic [3*DEPTH-1:0] preview,
  output logic [2:0]         hold_idx,
  output logic               hold_used,
  output logic               ready
);

  localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;
  localparam logic [15:0] TAPS     = 16'hB400;
  localparam logic [2:0]  EMPTY    = 3'd7;
  localparam logic [2:0]  DEPTH_C  = 3'(DEPTH);

  logic [15:0] lfsr;
  logic [15:0] lfsr_next;
  logic [2:0]  cnt;
  logic        pend;
  logic        pend_hold;
  logic [2:0]  pend_cur;

  assign lfsr_next = lfsr[0] ? ((lfsr >> 1) ^ TAPS) : (lfsr >> 1);

  logic [2:0] cand;
  logic       draw_ok;
  logic [2:0] draw_idx;

  assign cand = lfsr[2:0];

`ifdef PIECE_QUEUE_BAG_EN
  logic [6:0] bag_mask;
  logic [6:0] bag_set;
  logic [2:0] bag_start;
  logic [3:0] probe;
  logic       found;

  // First free bag index at or above candidate mod 7, wrapping 6 -> 0.
  // The mask is never full here because it clears on the 7th draw.
  always_comb begin
    bag_start = (cand == 3'd7) ? 3'd0 : cand;
    draw_idx  = EMPTY;
    found     = 1'b0;
    probe     = 4'd0;
    for (int k = 0; k < 7; k++) begin
      probe = {1'b0, bag_start} + 4'(k);
      if (probe >= 4'd7) probe = probe - 4'd7;
      if (!found && !bag_mask[probe[2:0]]) begin
        draw_idx = probe[2:0];
        found    = 1'b1;
      end
    end
    draw_ok = found;
    bag_set = bag_mask | (7'd1 << draw_idx);
  end
`else
  // Uniform draw: a candidate of 7 is not a piece, so skip this cycle.
  assign draw_ok  = (cand != EMPTY);
  assign draw_idx = cand;
`endif

  logic       head_ok;
  logic       new_hold;
  logic       take_spawn;
  logic       take_hold;
  logic       set_pend;
  logic [2:0] act_cur;
  logic       pop;

  assign head_ok = (cnt != 3'd0);

  // Request arbitration. A latched request has priority and blocks new ones;
  // spawn beats a simultaneous hold.
  always_comb begin
    new_hold   = hold_req && !spawn_req && !hold_used;
    take_spawn = 1'b0;
    take_hold  = 1'b0;
    set_pend   = 1'b0;
    act_cur    = hold_cur;
    if (pend) begin
      if (head_ok) begin
        take_spawn = !pend_hold;
        take_hold  = pend_hold;
        act_cur    = pend_cur;
      end
    end else if (spawn_req || new_hold) begin
      if (head_ok) begin
        take_spawn = spawn_req;
        take_hold  = new_hold;
      end else begin
        set_pend = 1'b1;
      end
    end
  end

  // A hold into an occupied slot swaps with it and leaves the queue alone.
  assign pop = take_spawn || (take_hold && (hold_idx == EMPTY));

  logic [3*DEPTH+2:0] shift_src;
  logic [3*DEPTH-1:0] q_next;
  logic [2:0]         cnt_pop;
  logic [2:0]         cnt_next;
  logic               append;

  assign shift_src = {EMPTY, preview};

  always_comb begin
    q_next  = pop ? shift_src[3*DEPTH+2:3] : preview;
    cnt_pop = pop ? (cnt - 3'd1) : cnt;
    append  = (cnt_pop < DEPTH_C) && draw_ok;
    for (int i = 0; i < DEPTH; i++) begin
      if (append && (cnt_pop == 3'(i))) q_next[3*i +: 3] = draw_idx;
    end
    cnt_next = cnt_pop + {2'b00, append};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr        <= SEED_EFF;
      cnt         <= 3'd0;
      preview     <= {DEPTH{EMPTY}};
      ready       <= 1'b0;
      spawn_valid <= 1'b0;
      spawn_idx   <= EMPTY;
      hold_idx    <= EMPTY;
      hold_used   <= 1'b0;
      pend        <= 1'b0;
      pend_hold   <= 1'b0;
      pend_cur    <= 3'd0;
`ifdef PIECE_QUEUE_BAG_EN
      bag_mask    <= 7'd0;
`endif
    end else begin
      lfsr        <= lfsr_next;
      cnt         <= cnt_next;
      preview     <= q_next;
      ready       <= (cnt_next == DEPTH_C);
      spawn_valid <= take_spawn || take_hold;
      if (take_spawn) begin
        spawn_idx <= preview[2:0];
        hold_used <= 1'b0;
      end
      if (take_hold) begin
        spawn_idx <= (hold_idx == EMPTY) ? preview[2:0] : hold_idx;
        hold_idx  <= act_cur;
        hold_used <= 1'b1;
      end
      if (set_pend) begin
        pend      <= 1'b1;
        pend_hold <= new_hold;
        pend_cur  <= hold_cur;
      end else if (pend && head_ok) begin
        pend <= 1'b0;
      end
`ifdef PIECE_QUEUE_BAG_EN
      if (append) bag_mask <= (bag_set == 7'h7F) ? 7'd0 : bag_set;
`endif
    end
  end

endmodule

// File: tb/tb_piece_queue.sv
// tb/tb_piece_queue.sv - self-checking bench for piece_queue
module tb_piece_queue;

  localparam int          DEPTH = 3;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic               spawn_req = 1'b0;
  logic               hold_req = 1'b0;
  logic [2:0]         hold_cur = 3'd0;
  logic               spawn_valid;
  logic [2:0]         spawn_idx;
  logic [3*DEPTH-1:0] preview;
  logic [2:0]         hold_idx;
  logic               hold_used;
  logic               ready;

  piece_queue #(.DEPTH(DEPTH), .SEED(SEED)) dut (
    .clk(clk), .rst(rst), .spawn_req(spawn_req), .hold_req(hold_req),
    .hold_cur(hold_cur), .spawn_valid(spawn_valid), .spawn_idx(spawn_idx),
    .preview(preview), .hold_idx(hold_idx), .hold_used(hold_used), .ready(ready)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [15:0] m_lfsr;
  logic [2:0]  m_q[$];
  logic [6:0]  m_mask;
  logic [2:0]  m_hold;
  logic        m_used;
  logic        m_pend;
  logic        m_pend_hold;
  logic [2:0]  m_pend_cur;
  logic        m_sv;
  logic [2:0]  exp_q[$];
  logic [2:0]  spawned[$];

  function automatic logic [15:0] galois(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  function automatic logic [3*DEPTH-1:0] model_preview();
    logic [3*DEPTH-1:0] v;
    for (int i = 0; i < DEPTH; i++) v[3*i +: 3] = (i < m_q.size()) ? m_q[i] : 3'd7;
    return v;
  endfunction

  task automatic model_edge();
    logic       do_sp;
    logic       do_ho;
    logic [2:0] cur;
    int         cand;
    int         idx;
    do_sp = 1'b0;
    do_ho = 1'b0;
    cur   = hold_cur;
    if (rst) begin
      m_lfsr = (SEED == 16'h0) ? 16'h0001 : SEED;
      m_q.delete();
      exp_q.delete();
      m_mask = 7'd0;
      m_hold = 3'd7;
      m_used = 1'b0;
      m_pend = 1'b0;
      m_sv   = 1'b0;
    end else begin
      if (m_pend) begin
        if (m_q.size() > 0) begin
          if (m_pend_hold) do_ho = 1'b1; else do_sp = 1'b1;
          cur    = m_pend_cur;
          m_pend = 1'b0;
        end
      end else if (spawn_req || (hold_req && !m_used)) begin
        if (m_q.size() == 0) begin
          m_pend      = 1'b1;
          m_pend_hold = !spawn_req;
          m_pend_cur  = hold_cur;
        end else if (spawn_req) do_sp = 1'b1;
        else do_ho = 1'b1;
      end
      m_sv = do_sp || do_ho;
      if (do_sp) begin
        exp_q.push_back(m_q.pop_front());
        m_used = 1'b0;
      end
      if (do_ho) begin
        if (m_hold == 3'd7) exp_q.push_back(m_q.pop_front());
        else exp_q.push_back(m_hold);
        m_hold = cur;
        m_used = 1'b1;
      end
      if (m_q.size() < DEPTH) begin
        cand = int'(m_lfsr[2:0]);
`ifdef PIECE_QUEUE_BAG_EN
        for (int k = 0; k < 7; k++) begin
          idx = ((cand % 7) + k) % 7;
          if (!m_mask[idx]) begin
            m_q.push_back(3'(idx));
            m_mask[idx] = 1'b1;
            break;
          end
        end
        if (m_mask == 7'h7F) m_mask = 7'd0;
`else
        if (cand != 7) m_q.push_back(3'(cand));
`endif
      end
      m_lfsr = galois(m_lfsr);
    end
  endtask

  // One clock: advance model with the sampled inputs, then compare outputs.
  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("spawn_valid", spawn_valid, m_sv);
    if (m_sv) begin
      check("spawn_idx", spawn_idx, exp_q.pop_front());
      spawned.push_back(spawn_idx);
    end
    check("preview", preview, model_preview());
    check("hold_idx", hold_idx, m_hold);
    check("hold_used", hold_used, m_used);
    check("ready", ready, m_q.size() == DEPTH);
  endtask

  initial begin
    int                 cyc;
    logic [2:0]         p0;
    logic [2:0]         p1;
    logic [3*DEPTH-1:0] pv;
    logic [6:0]         seen;

    // Reset and fill
    rst = 1'b1;
    step();
    step();
    check("rst_spawn_idx", spawn_idx, 3'd7);
    check("rst_preview", preview, {DEPTH{3'd7}});
    rst = 1'b0;
    cyc = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      cyc++;
      if (ready) break;
    end
    check("ready_cycles", cyc, DEPTH);
    check("fill_spawn_valid", spawn_valid, 1'b0);
    check("fill_hold_idx", hold_idx, 3'd7);
    for (int i = 0; i < DEPTH; i++) check("fill_slot_lt7", preview[3*i +: 3] < 3'd7, 1'b1);

    // 14 spawns, 4 cycles apart: aligned bag windows
    spawned.delete();
    for (int n = 0; n < 14; n++) begin
      p0 = m_q[0];
      p1 = m_q[1];
      spawn_req = 1'b1;
      step();
      spawn_req = 1'b0;
      check("lat_spawn_valid", spawn_valid, 1'b1);
      check("lat_spawn_idx", spawn_idx, p0);
      check("lat_shift", preview[2:0], p1);
      step(); step(); step();
    end
    check("bag_count", spawned.size(), 14);
    for (int w = 0; w < 2; w++) begin
      seen = 7'd0;
      for (int j = 0; j < 7; j++) begin
        if (spawned.size() > 7*w + j) begin
          check("spawn_lt7", spawned[7*w + j] < 3'd7, 1'b1);
          seen[spawned[7*w + j]] = 1'b1;
        end
      end
`ifdef PIECE_QUEUE_BAG_EN
      check("bag_perm", seen, 7'h7F);
`endif
    end

    // Hold sequence
    p0 = m_q[0];
    hold_req = 1'b1; hold_cur = 3'd2;
    step();
    hold_req = 1'b0;
    check("hold1_idx", hold_idx, 3'd2);
    check("hold1_used", hold_used, 1'b1);
    check("hold1_spawn", spawn_idx, p0);
    step();
    hold_req = 1'b1; hold_cur = 3'd4;
    step();
    hold_req = 1'b0;
    check("hold2_ignored", spawn_valid, 1'b0);
    step();
    spawn_req = 1'b1;
    step();
    spawn_req = 1'b0;
    check("spawn_clears_used", hold_used, 1'b0);
    step();
    pv = model_preview();
    hold_req = 1'b1; hold_cur = 3'd5;
    step();
    hold_req = 1'b0;
    check("swap_spawn_idx", spawn_idx, 3'd2);
    check("swap_hold_idx", hold_idx, 3'd5);
    check("swap_preview", preview, pv);
    step();

    // Collision
    p0 = m_q[0];
    spawn_req = 1'b1; hold_req = 1'b1; hold_cur = 3'd3;
    step();
    spawn_req = 1'b0; hold_req = 1'b0;
    check("coll_spawn_idx", spawn_idx, p0);
    check("coll_hold_idx", hold_idx, 3'd5);
    step();
    check("coll_single", spawn_valid, 1'b0);

    // Early request after a mid-operation reset
    rst = 1'b1;
    step();
    rst = 1'b0; spawn_req = 1'b1;
    step();
    spawn_req = 1'b0;
    check("early_pending", spawn_valid, 1'b0);
    step();
    check("early_spawn_valid", spawn_valid, 1'b1);
    check("early_spawn_idx", spawn_idx, 3'd1);

    // Random traffic with an occasional reset
    for (int i = 0; i < 200; i++) begin
      rst       = (i == 90);
      spawn_req = ($urandom_range(0, 3) == 0);
      hold_req  = ($urandom_range(0, 4) == 0);
      hold_cur  = 3'($urandom_range(0, 6));
      step();
    end
    rst = 1'b0; spawn_req = 1'b0; hold_req = 1'b0;
    step();
    check("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
